// File: rtl/life_array_param_if.sv
// Signal bundle for life_array_param: row access, run control, status and tile-edge exchange.
// The host side drives through master, the tile itself attaches through slave.
interface life_array_param_if #(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned SEL_W = 4,
    parameter int unsigned CNT_W = 16
);
    logic [COLS-1:0]  vali;
    logic [SEL_W-1:0] vali_selector;
    logic [SEL_W-1:0] valo_selector;
    logic             write_enb;
    logic             step;
    logic             run;
    logic [CNT_W-1:0] step_count;
    logic             stop;
    logic             wrap_mode;
    logic [COLS-1:0]  valo;
    logic [COLS-1:0]  valo_prev;

    logic [COLS-1:0]  ni;
    logic [COLS-1:0]  si;
    logic [ROWS-1:0]  wi;
    logic [ROWS-1:0]  ei;
    logic             nwi;
    logic             nei;
    logic             sei;
    logic             swi;
    logic [COLS-1:0]  no;
    logic [COLS-1:0]  so;
    logic [ROWS-1:0]  wo;
    logic [ROWS-1:0]  eo;
    logic             nwo;
    logic             neo;
    logic             seo;
    logic             swo;

    logic             busy;
    logic             done;
    logic             stable;
    logic [CNT_W-1:0] gen_count;

    modport master (
        output vali, vali_selector, valo_selector, write_enb, step, run, step_count, stop,
               wrap_mode, ni, si, wi, ei, nwi, nei, sei, swi,
        input  valo, valo_prev, no, so, wo, eo, nwo, neo, seo, swo,
               busy, done, stable, gen_count
    );

    modport slave (
        input  vali, vali_selector, valo_selector, write_enb, step, run, step_count, stop,
               wrap_mode, ni, si, wi, ei, nwi, nei, sei, swi,
        output valo, valo_prev, no, so, wo, eo, nwo, neo, seo, swo,
               busy, done, stable, gen_count
    );
endinterface

// File: rtl/life_array_param.sv
// ROWS x COLS Conway Life tile (B3/S23) with external or toroidal edges and a
// multi-generation run engine (busy/done handshake, abort, generation counter, stable flag).
module life_array_param #(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned SEL_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    life_array_param_if.slave bus
);

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    grid_t            cur_q, cur_d;
    grid_t            prev_q, prev_d;
    grid_t            next_grid;
    logic [CNT_W-1:0] gen_q, gen_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             stable_q, stable_d;
    logic             done_q, done_d;
    logic             do_gen;

    // cur surrounded by a one-cell halo; halo row/col 0 is north/west of the grid
    logic [ROWS+1:0][COLS+1:0] ext;

    always_comb begin
        ext = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                ext[r+1][c+1] = cur_q[r][c];
            end
            ext[r+1][0]      = bus.wrap_mode ? cur_q[r][COLS-1] : bus.wi[r];
            ext[r+1][COLS+1] = bus.wrap_mode ? cur_q[r][0]      : bus.ei[r];
        end
        for (int c = 0; c < COLS; c++) begin
            ext[0][c+1]      = bus.wrap_mode ? cur_q[ROWS-1][c] : bus.ni[c];
            ext[ROWS+1][c+1] = bus.wrap_mode ? cur_q[0][c]      : bus.si[c];
        end
        ext[0][0]           = bus.wrap_mode ? cur_q[ROWS-1][COLS-1] : bus.nwi;
        ext[0][COLS+1]      = bus.wrap_mode ? cur_q[ROWS-1][0]      : bus.nei;
        ext[ROWS+1][COLS+1] = bus.wrap_mode ? cur_q[0][0]           : bus.sei;
        ext[ROWS+1][0]      = bus.wrap_mode ? cur_q[0][COLS-1]      : bus.swi;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [3:0] cnt;
            assign cnt = 4'(ext[r][c])   + 4'(ext[r][c+1])   + 4'(ext[r][c+2])
                       + 4'(ext[r+1][c])                     + 4'(ext[r+1][c+2])
                       + 4'(ext[r+2][c]) + 4'(ext[r+2][c+1]) + 4'(ext[r+2][c+2]);
            assign next_grid[r][c] = (cnt == 4'd3) || (cur_q[r][c] && (cnt == 4'd2));
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        prev_d   = prev_q;
        gen_d    = gen_q;
        remain_d = remain_q;
        stable_d = stable_q;
        done_d   = 1'b0;
        do_gen   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.write_enb) begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (bus.vali_selector == SEL_W'(r)) begin
                            cur_d[r] = bus.vali;
                        end
                    end
                end else if (bus.run) begin
                    if (bus.step_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        remain_d = bus.step_count;
                        state_d  = StRun;
                    end
                end else if (bus.step) begin
                    do_gen = 1'b1;
                end
            end
            StRun: begin
                // Abort wins over the pending update, even on the final generation
                if (bus.stop) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    do_gen   = 1'b1;
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_gen) begin
            prev_d   = cur_q;
            cur_d    = next_grid;
            gen_d    = gen_q + CNT_W'(1);
            stable_d = (next_grid == cur_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cur_q    <= '0;
            prev_q   <= '0;
            gen_q    <= '0;
            remain_q <= '0;
            stable_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            prev_q   <= prev_d;
            gen_q    <= gen_d;
            remain_q <= remain_d;
            stable_q <= stable_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        bus.valo      = '0;
        bus.valo_prev = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (bus.valo_selector == SEL_W'(r)) begin
                bus.valo      = cur_q[r];
                bus.valo_prev = prev_q[r];
            end
        end
    end

    always_comb begin
        bus.wo = '0;
        bus.eo = '0;
        for (int r = 0; r < ROWS; r++) begin
            bus.wo[r] = cur_q[r][0];
            bus.eo[r] = cur_q[r][COLS-1];
        end
    end

    assign bus.no        = cur_q[0];
    assign bus.so        = cur_q[ROWS-1];
    assign bus.nwo       = cur_q[0][0];
    assign bus.neo       = cur_q[0][COLS-1];
    assign bus.seo       = cur_q[ROWS-1][COLS-1];
    assign bus.swo       = cur_q[ROWS-1][0];
    assign bus.busy      = (state_q == StRun);
    assign bus.done      = done_q;
    assign bus.stable    = stable_q;
    assign bus.gen_count = gen_q;

endmodule
